// File: rtl/lib_arbiter_pkg.sv
// Shared constants and FSM state type for the row readout grant scheduler.
package lib_arbiter_pkg;
  localparam int ROWS            = 8;
  localparam int DEF_TIMEOUT_CYC = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;
endpackage

// File: rtl/priority_arb.sv
// Fixed-priority arbiter: the lowest set request bit wins (port 0 highest).
module priority_arb #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  // Two's-complement trick isolates the lowest set bit.
  assign gnt_o = req_i & (~req_i + N'(1));
endmodule

// File: rtl/row_grant_sched.sv
// One-at-a-time row grant scheduler with ack watchdog.
// ROW_SCHED_RR_EN selects round-robin; undefined gives fixed priority.
module row_grant_sched
  import lib_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = ROWS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ack_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o,
  output logic               timeout_o,
  output logic               busy_o
);

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] win_gnt;

`ifdef ROW_SCHED_RR_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   ptr_q, ptr_d, ptr_nxt;
  logic [NUM_REQ-1:0] masked_req, masked_gnt, raw_gnt;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_mask
    assign masked_req[gi] = req_i[gi] & (IDX_W'(gi) >= ptr_q);
  end

  priority_arb #(.N(NUM_REQ)) u_masked_arb (.req_i(masked_req), .gnt_o(masked_gnt));
  priority_arb #(.N(NUM_REQ)) u_raw_arb    (.req_i(req_i),      .gnt_o(raw_gnt));

  assign win_gnt = (|masked_req) ? masked_gnt : raw_gnt;
  // Explicit wrap keeps the pointer in range for non-power-of-two NUM_REQ.
  assign ptr_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
`else
  priority_arb #(.N(NUM_REQ)) u_raw_arb (.req_i(req_i), .gnt_o(win_gnt));
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
`ifdef ROW_SCHED_RR_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (en_i && (|req_i)) begin
          gnt_d   = win_gnt;
          idx_d   = onehot_to_idx(win_gnt);
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end else begin
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 8'd1;
        // Ack takes precedence over a simultaneous watchdog expiry.
        if (ack_i || (cnt_q == 8'(TIMEOUT_CYC - 1))) begin
          gnt_d     = '0;
          idx_d     = '0;
          valid_d   = 1'b0;
          timeout_d = ~ack_i;
          state_d   = IDLE;
`ifdef ROW_SCHED_RR_EN
          ptr_d     = ptr_nxt;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef ROW_SCHED_RR_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end
`endif

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = (state_q == GRANT);

endmodule
